// File: rtl/fifo_flex.sv
// fifo_flex: parametrised single-clock synchronous FIFO.
//
// Purpose
//   Circular-buffer FIFO with a selectable read mode (registered or
//   first-word-fall-through), an occupancy counter, almost-full and
//   almost-empty thresholds, a synchronous flush and sticky error flags.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   clear         synchronous flush (same effect as rst on state)
//   wr_en, din    write request and data
//   rd_en         read (pop) request
//   dout          read data (registered when FWFT=0, head word when FWFT=1)
//   full, empty   occupancy == DEPTH / occupancy == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         occupancy 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
//
// Handshake
//   A write is accepted at a rising edge when wr_en=1 and full=0; a read is
//   accepted when rd_en=1 and empty=0. full/empty are the values before the
//   edge. Requests that are not accepted are dropped, never queued. While
//   rst or clear is high no request is accepted and no flag is raised.
//   No output depends combinationally on wr_en or rd_en.
module fifo_flex #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 32,
    parameter int POINTER_WIDTH = $clog2(DEPTH),
    parameter int FWFT          = 0,
    parameter int AF_THRESH     = DEPTH - 4,
    parameter int AE_THRESH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [POINTER_WIDTH:0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam logic [POINTER_WIDTH:0] PTR_ONE = 1;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [POINTER_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [POINTER_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [POINTER_WIDTH:0] count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;
    logic                   wr_acc, rd_acc;

    // The extra MSB on each pointer is the wrap bit: equal pointers mean
    // empty, equal low bits with differing wrap bits mean full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[POINTER_WIDTH] != rd_ptr_q[POINTER_WIDTH]) &&
                   (wr_ptr_q[POINTER_WIDTH-1:0] == rd_ptr_q[POINTER_WIDTH-1:0]);

    assign wr_acc = wr_en && !full  && !clear && !rst;
    assign rd_acc = rd_en && !empty && !clear && !rst;

    assign count        = count_q;
    assign almost_full  = (int'(count_q) >= AF_THRESH);
    assign almost_empty = (int'(count_q) <= AE_THRESH);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + PTR_ONE;
                2'b01:   count_d = count_q - PTR_ONE;
                default: count_d = count_q;
            endcase
            if (wr_en && full)  overflow_d  = 1'b1;
            if (rd_en && empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[POINTER_WIDTH-1:0]] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; meaningless while empty.
            assign dout = mem_q[rd_ptr_q[POINTER_WIDTH-1:0]];
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (clear)       dout_d = '0;
                else if (rd_acc) dout_d = mem_q[rd_ptr_q[POINTER_WIDTH-1:0]];
            end

            always_ff @(posedge clk) begin
                if (rst) dout_q <= '0;
                else     dout_q <= dout_d;
            end

            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
module tb_fifo_flex;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic rst, clear, wr_en, rd_en;
    logic [W-1:0] din;

    logic         full, almost_full, empty, almost_empty, overflow, underflow;
    logic [W-1:0] dout;
    logic [2:0]   count;

    logic         f_full, f_almost_full, f_empty, f_almost_empty, f_overflow, f_underflow;
    logic [W-1:0] f_dout;
    logic [2:0]   f_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain queue of stored words plus flag bits.
    logic [W-1:0] model_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_dout;
    logic         model_ovf, model_unf;

    always #5 clk = ~clk;

    fifo_flex #(.WIDTH(W), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .din(din),
        .full(full), .almost_full(almost_full), .rd_en(rd_en), .dout(dout),
        .empty(empty), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_flex #(.WIDTH(W), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
        .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .din(din),
        .full(f_full), .almost_full(f_almost_full), .rd_en(rd_en), .dout(f_dout),
        .empty(f_empty), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the model rules for one clock edge.
    task automatic model_edge(input logic we, input logic [W-1:0] d, input logic re,
                              input logic clr, input logic rs);
        logic was_full, was_empty;
        logic [W-1:0] v;
        if (rs || clr) begin
            model_q.delete();
            model_ovf  = 1'b0;
            model_unf  = 1'b0;
            model_dout = '0;
        end else begin
            was_full  = (model_q.size() == DEPTH);
            was_empty = (model_q.size() == 0);
            if (we && was_full)  model_ovf = 1'b1;
            if (re && was_empty) model_unf = 1'b1;
            if (re && !was_empty) begin
                v = model_q.pop_front();
                model_dout = v;
                exp_q.push_back(v);
            end
            if (we && !was_full) model_q.push_back(d);
        end
    endtask

    task automatic compare_all();
        int n;
        n = model_q.size();
        check("count", 32'(count), 32'(n));
        check("full", 32'(full), 32'(n == DEPTH));
        check("empty", 32'(empty), 32'(n == 0));
        check("almost_full", 32'(almost_full), 32'(n >= AF));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check("overflow", 32'(overflow), 32'(model_ovf));
        check("underflow", 32'(underflow), 32'(model_unf));
        check("dout_hold", 32'(dout), 32'(model_dout));
        check("ptr_diff", 32'(3'(u_dut.wr_ptr_q - u_dut.rd_ptr_q)), 32'(count));
        check("f_count", 32'(f_count), 32'(n));
        check("f_empty", 32'(f_empty), 32'(n == 0));
        check("f_full", 32'(f_full), 32'(n == DEPTH));
        check("f_overflow", 32'(f_overflow), 32'(model_ovf));
        check("f_underflow", 32'(f_underflow), 32'(model_unf));
        if (n != 0) check("f_head", 32'(f_dout), 32'(model_q[0]));
    endtask

    task automatic cycle(input logic we, input logic [W-1:0] d, input logic re,
                         input logic clr, input logic rs);
        @(negedge clk);
        wr_en = we; din = d; rd_en = re; clear = clr; rst = rs;
        @(posedge clk);
        model_edge(we, d, re, clr, rs);
        #1;
        compare_all();
    endtask

    // Monitor: whenever a read is accepted by the registered-mode FIFO, the
    // word it presents next must be the oldest expected word.
    initial begin : monitor
        logic fire;
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            fire = rd_en && !empty && !rst && !clear;
            #2;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_read: read data 0x%0h with nothing expected", dout);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_read", 32'(dout), 32'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [W-1:0] wd;
        rst = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        model_q.delete(); model_ovf = 1'b0; model_unf = 1'b0; model_dout = '0;

        // Reset state
        cycle(0, 8'h00, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 0);

        // Fill with four words, then drain in order
        cycle(1, 8'h11, 0, 0, 0);
        cycle(1, 8'h22, 0, 0, 0);
        cycle(1, 8'h33, 0, 0, 0);
        cycle(1, 8'h44, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);

        // Overflow: write into a full FIFO is dropped and the flag sticks
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'h60 + i), 0, 0, 0);
        cycle(1, 8'h55, 0, 0, 0);
        cycle(1, 8'h55, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);

        // Underflow, then read+write on empty
        cycle(0, 8'h00, 1, 0, 0);
        cycle(1, 8'hAA, 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);

        // Wrap-around at steady occupancy 2
        cycle(1, 8'h00, 0, 0, 0);
        cycle(1, 8'h01, 0, 0, 0);
        for (int i = 2; i < 10; i++) cycle(1, 8'(i), 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);

        // First-word-fall-through visibility (checked on u_fwft)
        cycle(1, 8'hA5, 0, 0, 0);
        cycle(1, 8'h5A, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);

        // Clear and reset mid-stream, with both requests asserted
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'hC0 + i), 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(1, 8'hEE, 1, 1, 0);
        cycle(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'hD0 + i), 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(1, 8'hEE, 1, 0, 1);
        cycle(0, 8'h00, 0, 0, 0);

        // Randomized traffic with phases biased towards filling and draining
        for (int i = 0; i < 600; i++) begin
            int wp, rp;
            wp = ((i / 50) % 2 == 0) ? 70 : 30;
            rp = 100 - wp;
            wd = 8'($urandom_range(0, 255));
            cycle(($urandom_range(0, 99) < wp), wd, ($urandom_range(0, 99) < rp),
                  ($urandom_range(0, 59) == 0), ($urandom_range(0, 119) == 0));
        end

        cycle(0, 8'h00, 0, 0, 0);
        #5;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
